// File: rtl/hazard_if.sv
// D-stage hazard interface: instruction fields going into the hazard controller, and the
// stall, flush, forwarding and MDU-busy decisions it returns in the same cycle.
interface hazard_if;
  logic [4:0] D_rs;
  logic [4:0] D_rt;
  logic [1:0] D_tuse_rs;
  logic [1:0] D_tuse_rt;
  logic [4:0] D_regaddr;
  logic       D_regwrite;
  logic [1:0] D_tnew;
  logic [1:0] D_md_start;
  logic       D_md_use;
  logic       D_stall;
  logic       E_flush;
  logic [1:0] fwd_rs_sel;
  logic [1:0] fwd_rt_sel;
  logic       md_busy;

  modport master (
    output D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_regaddr, D_regwrite, D_tnew,
           D_md_start, D_md_use,
    input  D_stall, E_flush, fwd_rs_sel, fwd_rt_sel, md_busy
  );

  modport slave (
    input  D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_regaddr, D_regwrite, D_tnew,
           D_md_start, D_md_use,
    output D_stall, E_flush, fwd_rs_sel, fwd_rt_sel, md_busy
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/forward scheduler for the 5-stage pipeline plus the mult/div busy counter.
// Define HAZARD_FWD_EN for forwarding with Tuse/Tnew stalling; otherwise readers wait for writeback.
module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic     clk,
  input  logic     reset,
  hazard_if.slave  hz
);

  localparam logic [3:0] MULT_LD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYCLES);

  logic [4:0] E_addr, M_addr, W_addr;
  logic       E_we, M_we, W_we;
  logic [1:0] E_tnew, M_tnew;
  logic [3:0] md_cnt;

  logic       stall_rs, stall_rt, stall_md, d_stall, md_busy;
  logic [1:0] rs_sel, rt_sel;

  function automatic logic [1:0] sat_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // Register $0 is hard-wired zero, so a write to it never creates a dependency.
  function automatic logic hit(input logic we, input logic [4:0] addr, input logic [4:0] src);
    return we && (addr != 5'd0) && (addr == src);
  endfunction

`ifdef HAZARD_FWD_EN
  function automatic logic src_stall(input logic [4:0] s, input logic [1:0] tuse);
    return (tuse != 2'd3) &&
           ((hit(E_we, E_addr, s) && (E_tnew > tuse)) ||
            (hit(M_we, M_addr, s) && (M_tnew > tuse)));
  endfunction

  // Only the nearest writer is a candidate; an E writer not yet done blocks older stages.
  function automatic logic [1:0] fwd_sel(input logic [4:0] s);
    if (hit(E_we, E_addr, s))      return (E_tnew == 2'd0) ? 2'd1 : 2'd0;
    else if (hit(M_we, M_addr, s)) return 2'd2;
    else if (hit(W_we, W_addr, s)) return 2'd3;
    else                           return 2'd0;
  endfunction

  always_comb begin
    stall_rs = src_stall(hz.D_rs, hz.D_tuse_rs);
    stall_rt = src_stall(hz.D_rt, hz.D_tuse_rt);
    rs_sel   = fwd_sel(hz.D_rs);
    rt_sel   = fwd_sel(hz.D_rt);
  end
`else
  function automatic logic src_stall(input logic [4:0] s, input logic [1:0] tuse);
    return (tuse != 2'd3) &&
           (hit(E_we, E_addr, s) || hit(M_we, M_addr, s) || hit(W_we, W_addr, s));
  endfunction

  always_comb begin
    stall_rs = src_stall(hz.D_rs, hz.D_tuse_rs);
    stall_rt = src_stall(hz.D_rt, hz.D_tuse_rt);
    rs_sel   = 2'd0;
    rt_sel   = 2'd0;
  end
`endif

  always_comb begin
    md_busy  = (md_cnt != 4'd0);
    stall_md = hz.D_md_use && md_busy;
    d_stall  = stall_rs || stall_rt || stall_md;
  end

  assign hz.D_stall    = d_stall;
  assign hz.E_flush    = d_stall;
  assign hz.fwd_rs_sel = rs_sel;
  assign hz.fwd_rt_sel = rt_sel;
  assign hz.md_busy    = md_busy;

  // Shadow pipeline: E <- D (or bubble on stall), M <- E, W <- M
  always_ff @(posedge clk) begin
    if (reset) begin
      E_addr <= 5'd0;
      E_we   <= 1'b0;
      E_tnew <= 2'd0;
      M_addr <= 5'd0;
      M_we   <= 1'b0;
      M_tnew <= 2'd0;
      W_addr <= 5'd0;
      W_we   <= 1'b0;
      md_cnt <= 4'd0;
    end else begin
      W_addr <= M_addr;
      W_we   <= M_we;
      M_addr <= E_addr;
      M_we   <= E_we;
      M_tnew <= sat_dec(E_tnew);
      if (d_stall) begin
        E_addr <= 5'd0;
        E_we   <= 1'b0;
        E_tnew <= 2'd0;
      end else begin
        E_addr <= hz.D_regaddr;
        E_we   <= hz.D_regwrite;
        E_tnew <= hz.D_tnew;
      end
      // A start can only be accepted when the instruction actually leaves D.
      if ((hz.D_md_start != 2'd0) && !d_stall)
        md_cnt <= (hz.D_md_start == 2'd1) ? MULT_LD : DIV_LD;
      else if (md_cnt != 4'd0)
        md_cnt <= md_cnt - 4'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; expectations follow HAZARD_FWD_EN when defined.
module tb_hazard_ctrl;

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  hazard_if hz ();

  hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    hz.D_rs       = 5'd0;
    hz.D_rt       = 5'd0;
    hz.D_tuse_rs  = 2'd3;
    hz.D_tuse_rt  = 2'd3;
    hz.D_regaddr  = 5'd0;
    hz.D_regwrite = 1'b0;
    hz.D_tnew     = 2'd0;
    hz.D_md_start = 2'd0;
    hz.D_md_use   = 1'b0;
  endtask

  // Push a register writer from D into E, then leave D idle.
  task automatic issue(input logic [4:0] addr, input logic [1:0] tnew);
    set_idle();
    hz.D_regaddr  = addr;
    hz.D_regwrite = 1'b1;
    hz.D_tnew     = tnew;
    tick();
    set_idle();
  endtask

  initial begin
    int n;
    set_idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_stall", hz.D_stall, 0);
    chk("rst_flush", hz.E_flush, 0);
    chk("rst_rs_sel", hz.fwd_rs_sel, 0);
    chk("rst_rt_sel", hz.fwd_rt_sel, 0);
    chk("rst_busy", hz.md_busy, 0);

    // ALU $1 in E, branch reads $1 in D
    issue(5'd1, 2'd1);
    hz.D_rs = 5'd1; hz.D_tuse_rs = 2'd0;
    #1;
    chk("t1a_stall", hz.D_stall, 1);
    chk("t1a_flush", hz.E_flush, 1);
    tick();
    chk("t1b_stall", hz.D_stall, FWD ? 0 : 1);
    chk("t1b_rs_sel", hz.fwd_rs_sel, FWD ? 2 : 0);
    tick();
    chk("t1c_stall", hz.D_stall, FWD ? 0 : 1);
    chk("t1c_rs_sel", hz.fwd_rs_sel, FWD ? 3 : 0);
    tick();
    chk("t1d_stall", hz.D_stall, 0);
    chk("t1d_rs_sel", hz.fwd_rs_sel, 0);
    set_idle();

    // load $2 in E; D reads $2 as rt (tuse1) and writes $6 while reading $6
    issue(5'd2, 2'd2);
    hz.D_rt = 5'd2; hz.D_tuse_rt = 2'd1;
    hz.D_rs = 5'd6; hz.D_tuse_rs = 2'd0;
    hz.D_regaddr = 5'd6; hz.D_regwrite = 1'b1; hz.D_tnew = 2'd1;
    #1;
    chk("t2a_stall", hz.D_stall, 1);
    tick();
    chk("t2b_stall", hz.D_stall, FWD ? 0 : 1);
    chk("t2b_rt_sel", hz.fwd_rt_sel, FWD ? 2 : 0);
    chk("t2b_rs_sel", hz.fwd_rs_sel, 0);
    hz.D_tuse_rs = 2'd3; hz.D_regwrite = 1'b0; hz.D_regaddr = 5'd0;
    tick();
    chk("t2c_stall", hz.D_stall, FWD ? 0 : 1);
    chk("t2c_rt_sel", hz.fwd_rt_sel, FWD ? 3 : 0);
    tick();
    chk("t2d_stall", hz.D_stall, 0);
    chk("t2d_rt_sel", hz.fwd_rt_sel, 0);
    set_idle();

    // ALU $3 in M with tnew0, reader tuse1
    issue(5'd3, 2'd1);
    tick();
    hz.D_rs = 5'd3; hz.D_tuse_rs = 2'd1;
    #1;
    chk("t3_stall", hz.D_stall, FWD ? 0 : 1);
    chk("t3_rs_sel", hz.fwd_rs_sel, FWD ? 2 : 0);
    set_idle();
    tick(); tick(); tick();
    // writer of $0 in E never matches
    issue(5'd0, 2'd1);
    hz.D_tuse_rs = 2'd0; hz.D_tuse_rt = 2'd0;
    #1;
    chk("t3z_stall", hz.D_stall, 0);
    chk("t3z_rs_sel", hz.fwd_rs_sel, 0);
    chk("t3z_rt_sel", hz.fwd_rt_sel, 0);
    set_idle();
    // tuse=3 means the source is not read
    issue(5'd5, 2'd2);
    hz.D_rs = 5'd5; hz.D_tuse_rs = 2'd3;
    #1;
    chk("t3n_stall", hz.D_stall, 0);
    set_idle();
    tick(); tick(); tick();

    // stalled D writer must become a bubble, not enter E
    issue(5'd1, 2'd1);
    hz.D_rs = 5'd1; hz.D_tuse_rs = 2'd0;
    hz.D_regaddr = 5'd8; hz.D_regwrite = 1'b1; hz.D_tnew = 2'd1;
    #1;
    chk("t7a_stall", hz.D_stall, 1);
    tick();
    set_idle();
    hz.D_rs = 5'd8; hz.D_tuse_rs = 2'd0;
    #1;
    chk("t7b_stall", hz.D_stall, 0);
    set_idle();
    tick(); tick(); tick();

    // div then mflo: exactly 10 stalled cycles
    hz.D_md_start = 2'd2; hz.D_md_use = 1'b1;
    #1;
    chk("t4_issue_stall", hz.D_stall, 0);
    tick();
    hz.D_md_start = 2'd0; hz.D_md_use = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("t4_stall_%0d", i), hz.D_stall, 1);
      chk($sformatf("t4_busy_%0d", i), hz.md_busy, 1);
      tick();
    end
    chk("t4_end_busy", hz.md_busy, 0);
    chk("t4_end_stall", hz.D_stall, 0);
    set_idle();

    // mult keeps the unit busy 5 cycles; busy alone does not stall
    hz.D_md_start = 2'd1;
    tick();
    set_idle();
    #1;
    chk("mult_nouse_stall", hz.D_stall, 0);
    n = 0;
    while (hz.md_busy === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    chk("mult_cycles", 4'(n), 5);

    // start attempted while stalled must not load the counter
    issue(5'd1, 2'd1);
    hz.D_rs = 5'd1; hz.D_tuse_rs = 2'd0; hz.D_md_start = 2'd1;
    tick();
    set_idle();
    #1;
    chk("stalled_start_busy", hz.md_busy, 0);
    tick(); tick(); tick();

    // reset in the middle of a div
    hz.D_md_start = 2'd2;
    tick();
    set_idle();
    tick(); tick(); tick();
    issue(5'd7, 2'd2);
    chk("t5_pre_busy", hz.md_busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("t5_busy", hz.md_busy, 0);
    chk("t5_stall", hz.D_stall, 0);
    chk("t5_flush", hz.E_flush, 0);
    chk("t5_rs_sel", hz.fwd_rs_sel, 0);
    chk("t5_rt_sel", hz.fwd_rt_sel, 0);
    hz.D_rs = 5'd7; hz.D_tuse_rs = 2'd0; hz.D_md_use = 1'b1;
    #1;
    chk("t5_post_stall", hz.D_stall, 0);
    set_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
